// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: widths, opcode/operand encodings, bubble word and FSM states.
package instruction_fetch_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 16;
  localparam int unsigned INSN_WIDTH_DEF = 28;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_STO = 4'h3;
  localparam logic [3:0] OP_LED = 4'h9;

  // Operand field encodings used by the program image: 8-bit register, 16-bit immediate.
  localparam logic [7:0]  REG_R2 = 8'd2;
  localparam logic [15:0] IMM_H  = 16'h0048;

  localparam logic [INSN_WIDTH_DEF-1:0] BUBBLE_WORD = {OP_NOP, 24'd0};

  typedef enum logic [1:0] {
    S_BOOT     = 2'd0,
    S_RUN      = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

endpackage

// File: rtl/instruction_fetch_pc_register.sv
// Program counter with synchronous active-low reset, load, hold and modulo-2^N increment.
module instruction_fetch_pc_register #(
  parameter int unsigned          ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iLoad,
  input  logic [ADDR_WIDTH-1:0] iLoadValue,
  input  logic                  iHold,
  output logic [ADDR_WIDTH-1:0] oPC
);

  logic [ADDR_WIDTH-1:0] r_pc;

  // Load beats hold so a branch always redirects, even while decode is stalled.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_pc <= RESET_PC;
    end else if (iLoad) begin
      r_pc <= iLoadValue;
    end else if (!iHold) begin
      r_pc <= r_pc + ADDR_WIDTH'(1);
    end
  end

  assign oPC = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives ROM address from the PC and registers {instruction, PC, valid} for decode.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned          INSN_WIDTH = INSN_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic [ADDR_WIDTH-1:0] oAddress,
  input  logic [INSN_WIDTH-1:0] iInstruction,
  input  logic                  iStall,
  input  logic                  iBranchTaken,
  input  logic [ADDR_WIDTH-1:0] iBranchTarget,
  output logic [INSN_WIDTH-1:0] oInstruction,
  output logic [ADDR_WIDTH-1:0] oPC,
  output logic                  oValid,
  output state_t                oState
);

  localparam logic [INSN_WIDTH-1:0] BUBBLE = {OP_NOP, {(INSN_WIDTH-4){1'b0}}};

  logic [ADDR_WIDTH-1:0] w_pc;
  logic [INSN_WIDTH-1:0] r_insn;
  logic [ADDR_WIDTH-1:0] r_opc;
  logic                  r_valid;
  state_t                r_state;

  instruction_fetch_pc_register #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .Clock      (Clock),
    .Reset      (Reset),
    .iLoad      (iBranchTaken),
    .iLoadValue (iBranchTarget),
    .iHold      (iStall),
    .oPC        (w_pc)
  );

  // Handshake: oValid marks a real instruction; iStall is decode's not-ready and freezes
  // the whole stage (PC and output registers) until it drops. A branch squashes instead.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_insn  <= BUBBLE;
      r_opc   <= '0;
      r_valid <= 1'b0;
      r_state <= S_BOOT;
    end else if (iBranchTaken) begin
      r_insn  <= BUBBLE;
      r_valid <= 1'b0;
      r_state <= S_REDIRECT;
    end else if (!iStall) begin
      r_insn  <= iInstruction;
      r_opc   <= w_pc;
      r_valid <= 1'b1;
      r_state <= S_RUN;
    end
  end

  assign oAddress     = w_pc;
  assign oInstruction = r_insn;
  assign oPC          = r_opc;
  assign oValid       = r_valid;
  assign oState       = r_state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch with a behavioural ROM fed by oAddress and a queue-based scoreboard.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam int AW = 16;
  localparam int IW = 28;
  localparam int SW = AW + 1 + AW + IW;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic [AW-1:0] oAddress;
  logic [IW-1:0] iInstruction;
  logic          iStall = 1'b0;
  logic          iBranchTaken = 1'b0;
  logic [AW-1:0] iBranchTarget = '0;
  logic [IW-1:0] oInstruction;
  logic [AW-1:0] oPC;
  logic          oValid;
  state_t        oState;

  int vectors = 0;
  int miscompares = 0;

  logic [SW-1:0] exp_q[$];

  logic [AW-1:0] m_pc;
  logic          m_valid;
  logic [AW-1:0] m_opc;
  logic [IW-1:0] m_insn;

  // Clock / reset block
  always #5 Clock = ~Clock;

  instruction_fetch dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .oAddress      (oAddress),
    .iInstruction  (iInstruction),
    .iStall        (iStall),
    .iBranchTaken  (iBranchTaken),
    .iBranchTarget (iBranchTarget),
    .oInstruction  (oInstruction),
    .oPC           (oPC),
    .oValid        (oValid),
    .oState        (oState)
  );

  function automatic logic [IW-1:0] rom(input logic [AW-1:0] a);
    case (a)
      16'h0000: rom = {OP_NOP, 24'd4000};
      16'h0003: rom = {OP_STO, REG_R2, IMM_H};
      16'h0010: rom = {OP_LED, 24'b10101010};
      default:  rom = {a[3:0] ^ 4'h5, 8'hC3, a};
    endcase
  endfunction

  assign iInstruction = rom(oAddress);

  // Driver: applies one cycle of stimulus, advances the reference model and queues its result.
  task automatic drive_cycle(input logic rst, input logic stall, input logic br,
                             input logic [AW-1:0] tgt);
    Reset = rst; iStall = stall; iBranchTaken = br; iBranchTarget = tgt;
    if (!rst) begin
      m_pc = '0; m_insn = {OP_NOP, 24'd0}; m_opc = '0; m_valid = 1'b0;
    end else if (br) begin
      m_pc = tgt; m_insn = {OP_NOP, 24'd0}; m_valid = 1'b0;
    end else if (!stall) begin
      m_insn = rom(m_pc); m_opc = m_pc; m_valid = 1'b1; m_pc = m_pc + 16'd1;
    end
    exp_q.push_back({m_pc, m_valid, m_opc, m_insn});
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    logic [SW-1:0] exp;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(i == 2, 1'b0, 1'b0, 16'h1234);
      exp = exp_q.pop_front(); vectors++;
      if ({oAddress, oValid, oPC, oInstruction} !== exp) begin
        miscompares++;
        $display("FAIL reset_sb cyc=%0d got=%h exp=%h", i, {oAddress, oValid, oPC, oInstruction}, exp);
      end
      if (i == 1) begin
        vectors++;
        if (oAddress !== 16'd0 || oValid !== 1'b0 || oState !== S_BOOT) begin
          miscompares++;
          $display("FAIL reset_state addr=%h valid=%b state=%0d exp 0/0/S_BOOT", oAddress, oValid, oState);
        end
      end
    end
    vectors++;
    if (oValid !== 1'b1 || oPC !== 16'd0 || oInstruction !== {OP_NOP, 24'd4000}) begin
      miscompares++;
      $display("FAIL reset_first valid=%b pc=%h insn=%h exp 1/0000/%h", oValid, oPC, oInstruction,
               {OP_NOP, 24'd4000});
    end
  endtask

  task automatic test_free_run();
    logic [SW-1:0] exp;
    for (int i = 1; i <= 4; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 16'hBEEF);
      exp = exp_q.pop_front(); vectors++;
      if ({oAddress, oValid, oPC, oInstruction} !== exp) begin
        miscompares++;
        $display("FAIL free_run_sb got=%h exp=%h", {oAddress, oValid, oPC, oInstruction}, exp);
      end
      vectors++;
      if (oPC !== AW'(i)) begin
        miscompares++;
        $display("FAIL free_run_pc got=%h exp=%h", oPC, AW'(i));
      end
      if (i == 3) begin
        vectors++;
        if (oInstruction !== {OP_STO, REG_R2, IMM_H}) begin
          miscompares++;
          $display("FAIL free_run_sto got=%h exp=%h", oInstruction, {OP_STO, REG_R2, IMM_H});
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [SW-1:0] exp;
    for (int i = 0; i < 8; i++) begin
      // cycle 0 resets, 1..3 advance to oPC=2, 4..6 stall, 7 releases
      drive_cycle(i != 0, (i >= 4 && i <= 6), 1'b0, 16'h0077);
      exp = exp_q.pop_front(); vectors++;
      if ({oAddress, oValid, oPC, oInstruction} !== exp) begin
        miscompares++;
        $display("FAIL stall_sb cyc=%0d got=%h exp=%h", i, {oAddress, oValid, oPC, oInstruction}, exp);
      end
      if (i >= 3 && i <= 6) begin
        vectors++;
        if (oAddress !== 16'd3 || oPC !== 16'd2 || oValid !== 1'b1) begin
          miscompares++;
          $display("FAIL stall_hold cyc=%0d addr=%h pc=%h valid=%b exp 0003/0002/1", i, oAddress, oPC, oValid);
        end
      end
    end
    vectors++;
    if (oPC !== 16'd3) begin
      miscompares++;
      $display("FAIL stall_release pc=%h exp=0003", oPC);
    end
  endtask

  task automatic test_branch_with_stall();
    logic [SW-1:0] exp;
    drive_cycle(1'b1, 1'b1, 1'b1, 16'h0010);
    exp = exp_q.pop_front(); vectors++;
    if ({oAddress, oValid, oPC, oInstruction} !== exp) begin
      miscompares++;
      $display("FAIL branch_sb got=%h exp=%h", {oAddress, oValid, oPC, oInstruction}, exp);
    end
    vectors++;
    if (oAddress !== 16'h0010 || oValid !== 1'b0 || oState !== S_REDIRECT) begin
      miscompares++;
      $display("FAIL branch_bubble addr=%h valid=%b state=%0d exp 0010/0/S_REDIRECT", oAddress, oValid, oState);
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    exp = exp_q.pop_front(); vectors++;
    if ({oAddress, oValid, oPC, oInstruction} !== exp) begin
      miscompares++;
      $display("FAIL branch_sb2 got=%h exp=%h", {oAddress, oValid, oPC, oInstruction}, exp);
    end
    vectors++;
    if (oValid !== 1'b1 || oPC !== 16'h0010 || oInstruction !== {OP_LED, 24'b10101010}) begin
      miscompares++;
      $display("FAIL branch_target valid=%b pc=%h insn=%h exp 1/0010/%h", oValid, oPC, oInstruction,
               {OP_LED, 24'b10101010});
    end
  endtask

  task automatic test_wrap();
    logic [SW-1:0] exp;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, i == 0, 16'hFFFF);
      exp = exp_q.pop_front(); vectors++;
      if ({oAddress, oValid, oPC, oInstruction} !== exp) begin
        miscompares++;
        $display("FAIL wrap_sb cyc=%0d got=%h exp=%h", i, {oAddress, oValid, oPC, oInstruction}, exp);
      end
      if (i == 1) begin
        vectors++;
        if (oPC !== 16'hFFFF || oAddress !== 16'h0000 || oValid !== 1'b1) begin
          miscompares++;
          $display("FAIL wrap_ffff pc=%h addr=%h valid=%b exp FFFF/0000/1", oPC, oAddress, oValid);
        end
      end
      if (i == 2) begin
        vectors++;
        if (oPC !== 16'h0000 || oAddress !== 16'h0001) begin
          miscompares++;
          $display("FAIL wrap_zero pc=%h addr=%h exp 0000/0001", oPC, oAddress);
        end
      end
    end
  endtask

  task automatic test_reset_mid_redirect();
    logic [SW-1:0] exp;
    for (int i = 0; i < 3; i++) begin
      // branch, then reset while redirecting, then release
      drive_cycle(i != 1, 1'b0, i == 0, 16'h0055);
      exp = exp_q.pop_front(); vectors++;
      if ({oAddress, oValid, oPC, oInstruction} !== exp) begin
        miscompares++;
        $display("FAIL rst_redir_sb cyc=%0d got=%h exp=%h", i, {oAddress, oValid, oPC, oInstruction}, exp);
      end
      if (i == 1) begin
        vectors++;
        if (oAddress !== 16'd0 || oValid !== 1'b0 || oPC !== 16'd0 ||
            oInstruction !== {OP_NOP, 24'd0} || oState !== S_BOOT) begin
          miscompares++;
          $display("FAIL rst_redir_state addr=%h valid=%b pc=%h insn=%h state=%0d exp reset values",
                   oAddress, oValid, oPC, oInstruction, oState);
        end
      end
    end
    vectors++;
    if (oValid !== 1'b1 || oPC !== 16'd0 || oInstruction !== {OP_NOP, 24'd4000}) begin
      miscompares++;
      $display("FAIL rst_redir_first valid=%b pc=%h insn=%h", oValid, oPC, oInstruction);
    end
  endtask

  task automatic test_random();
    logic [SW-1:0] exp;
    for (int i = 0; i < 300; i++) begin
      drive_cycle($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) == 0, AW'($urandom_range(0, 65535)));
      exp = exp_q.pop_front(); vectors++;
      if ({oAddress, oValid, oPC, oInstruction} !== exp) begin
        miscompares++;
        $display("FAIL random_sb cyc=%0d got=%h exp=%h", i, {oAddress, oValid, oPC, oInstruction}, exp);
      end
    end
  endtask

  initial begin
    @(negedge Clock);
    test_reset();
    test_free_run();
    test_stall();
    test_branch_with_stall();
    test_wrap();
    test_reset_mid_redirect();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
